// File: rtl/dsa_pkg.sv
// Shared types and Q8 constants for the bilinear pixel engine.
package dsa_pkg;

  localparam int          FRAC_W    = 8;
  localparam logic [8:0]  ONE_Q8    = 9'd256;
  localparam logic [27:0] ROUND_Q16 = 28'd32768;

  typedef logic [7:0] pixel_t;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_COORD = 4'd1,
    S_RD0   = 4'd2,
    S_RD1   = 4'd3,
    S_RD2   = 4'd4,
    S_RD3   = 4'd5,
    S_WAIT  = 4'd6,
    S_CALC  = 4'd7,
    S_WRITE = 4'd8
  } state_t;

endpackage

// File: rtl/dsa_bilinear_mac.sv
// Combinational Q8 bilinear blend of four neighbours with rounding and saturation.
module dsa_bilinear_mac
  import dsa_pkg::*;
(
  input  pixel_t     p00,
  input  pixel_t     p01,
  input  pixel_t     p10,
  input  pixel_t     p11,
  input  logic [7:0] fx,
  input  logic [7:0] fy,
  output pixel_t     pix
);

  logic [8:0]  wx0_s, wx1_s, wy0_s, wy1_s;
  logic [27:0] acc_s, scaled_s;

  function automatic logic [27:0] term(input pixel_t p, input logic [8:0] wx, input logic [8:0] wy);
    return {20'd0, p} * {19'd0, wx} * {19'd0, wy};
  endfunction

  // Weighted sum of the four taps; weights always total 65536 so the result stays in range
  always_comb begin
    wx1_s    = {1'b0, fx};
    wx0_s    = ONE_Q8 - wx1_s;
    wy1_s    = {1'b0, fy};
    wy0_s    = ONE_Q8 - wy1_s;
    acc_s    = term(p00, wx0_s, wy0_s) + term(p01, wx1_s, wy0_s)
             + term(p10, wx0_s, wy1_s) + term(p11, wx1_s, wy1_s) + ROUND_Q16;
    scaled_s = acc_s >> 5'd16;
    if (scaled_s > 28'd255) begin
      pix = 8'hFF;
    end else begin
      pix = scaled_s[7:0];
    end
  end

endmodule

// File: rtl/dsa_bilinear_pixel_engine.sv
// Per-pixel datapath: source coordinates, four-tap fetch, Q8 blend, one byte written.
module dsa_bilinear_pixel_engine #(
  parameter int IMG_WIDTH  = 512,
  parameter int IMG_HEIGHT = 512,
  parameter int ADDR_W     = 18,
  parameter int FRAC_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic [9:0]        out_width,
  input  logic [15:0]       scale_step,
  input  logic              pixel_req,
  input  logic [15:0]       pixel_index,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              wr_en,
  output logic [15:0]       wr_addr,
  output logic [7:0]        wr_data,
  output logic              done_pixel,
  output logic              busy
);
  import dsa_pkg::*;

  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT);
  localparam int PW = 26;                  // 10-bit dst coordinate times 16-bit step
  localparam int IW = PW - FRAC_W;         // integer part of the source coordinate
  localparam logic [IW-1:0] X_LAST = IW'(IMG_WIDTH - 1);
  localparam logic [IW-1:0] Y_LAST = IW'(IMG_HEIGHT - 1);

  state_t              state_r, state_next_s;
  logic [9:0]          dst_x_r, dst_y_r;
  logic [15:0]         idx_r;
  logic [XW-1:0]       x0_r, x1_r, x0_c_s, x1_c_s;
  logic [YW-1:0]       y0_r, y1_r, y0_c_s, y1_c_s;
  logic [FRAC_W-1:0]   fx_r, fy_r;
  logic [PW-1:0]       sx_s, sy_s;
  pixel_t              p00_r, p01_r, p10_r, p11_r, mac_pix_s;
  logic [ADDR_W-1:0]   rd_addr_next_s;

  function automatic logic [ADDR_W-1:0] src_addr(input logic [YW-1:0] y, input logic [XW-1:0] x);
    return ADDR_W'(y) * ADDR_W'(IMG_WIDTH) + ADDR_W'(x);
  endfunction

  // Source position of the current destination pixel with edge-clamped neighbours
  always_comb begin
    sx_s = {16'd0, dst_x_r} * {10'd0, scale_step};
    sy_s = {16'd0, dst_y_r} * {10'd0, scale_step};
    if (sx_s[PW-1:FRAC_W] > X_LAST) begin
      x0_c_s = X_LAST[XW-1:0];
    end else begin
      x0_c_s = sx_s[FRAC_W+XW-1:FRAC_W];
    end
    if (sy_s[PW-1:FRAC_W] > Y_LAST) begin
      y0_c_s = Y_LAST[YW-1:0];
    end else begin
      y0_c_s = sy_s[FRAC_W+YW-1:FRAC_W];
    end
    if (x0_c_s == X_LAST[XW-1:0]) begin
      x1_c_s = x0_c_s;
    end else begin
      x1_c_s = x0_c_s + XW'(1);
    end
    if (y0_c_s == Y_LAST[YW-1:0]) begin
      y1_c_s = y0_c_s;
    end else begin
      y1_c_s = y0_c_s + YW'(1);
    end
  end

  // Next-state decode; frame_start overrides everything and returns to idle
  always_comb begin
    state_next_s = state_r;
    if (frame_start) begin
      state_next_s = S_IDLE;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (pixel_req) begin
            state_next_s = S_COORD;
          end else begin
            state_next_s = S_IDLE;
          end
        end
        S_COORD: state_next_s = S_RD0;
        S_RD0:   state_next_s = S_RD1;
        S_RD1:   state_next_s = S_RD2;
        S_RD2:   state_next_s = S_RD3;
        S_RD3:   state_next_s = S_WAIT;
        S_WAIT:  state_next_s = S_CALC;
        S_CALC:  state_next_s = S_WRITE;
        S_WRITE: state_next_s = S_IDLE;
        default: state_next_s = S_IDLE;
      endcase
    end
  end

  // Address for the read state being entered; held when no read is launched
  always_comb begin
    rd_addr_next_s = rd_addr;
    if (frame_start) begin
      rd_addr_next_s = rd_addr;
    end else begin
      case (state_r)
        S_COORD: rd_addr_next_s = src_addr(y0_c_s, x0_c_s);
        S_RD0:   rd_addr_next_s = src_addr(y0_r, x1_r);
        S_RD1:   rd_addr_next_s = src_addr(y1_r, x0_r);
        S_RD2:   rd_addr_next_s = src_addr(y1_r, x1_r);
        default: rd_addr_next_s = rd_addr;
      endcase
    end
  end

  // State register and strobes registered from the state being entered
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r    <= S_IDLE;
      busy       <= 1'b0;
      rd_en      <= 1'b0;
      rd_addr    <= {ADDR_W{1'b0}};
      wr_en      <= 1'b0;
      done_pixel <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      busy       <= (state_next_s != S_IDLE);
      rd_en      <= (state_next_s == S_RD0) || (state_next_s == S_RD1) ||
                    (state_next_s == S_RD2) || (state_next_s == S_RD3);
      rd_addr    <= rd_addr_next_s;
      wr_en      <= (state_next_s == S_WRITE);
      done_pixel <= (state_next_s == S_WRITE);
    end
  end

  // Index, coordinate and neighbour latches; each tap lands one cycle after its read
  always_ff @(posedge clk) begin
    if (!rst) begin
      idx_r <= 16'd0;
      x0_r  <= {XW{1'b0}};
      x1_r  <= {XW{1'b0}};
      y0_r  <= {YW{1'b0}};
      y1_r  <= {YW{1'b0}};
      fx_r  <= {FRAC_W{1'b0}};
      fy_r  <= {FRAC_W{1'b0}};
      p00_r <= 8'd0;
      p01_r <= 8'd0;
      p10_r <= 8'd0;
      p11_r <= 8'd0;
    end else begin
      if ((state_r == S_IDLE) && (state_next_s == S_COORD)) begin
        idx_r <= pixel_index;
      end
      if (state_r == S_COORD) begin
        x0_r <= x0_c_s;
        x1_r <= x1_c_s;
        y0_r <= y0_c_s;
        y1_r <= y1_c_s;
        fx_r <= sx_s[FRAC_W-1:0];
        fy_r <= sy_s[FRAC_W-1:0];
      end
      if (!frame_start) begin
        case (state_r)
          S_RD1:   p00_r <= rd_data;
          S_RD2:   p01_r <= rd_data;
          S_RD3:   p10_r <= rd_data;
          S_WAIT:  p11_r <= rd_data;
          default: p00_r <= p00_r;
        endcase
      end
    end
  end

  // Blend result and destination address, captured on the way into the write state
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_data <= 8'd0;
      wr_addr <= 16'd0;
    end else if ((state_r == S_CALC) && (state_next_s == S_WRITE)) begin
      wr_data <= mac_pix_s;
      wr_addr <= idx_r;
    end
  end

  // Destination raster position: advances after each written pixel, cleared by frame_start
  always_ff @(posedge clk) begin
    if (!rst) begin
      dst_x_r <= 10'd0;
      dst_y_r <= 10'd0;
    end else if (frame_start) begin
      dst_x_r <= 10'd0;
      dst_y_r <= 10'd0;
    end else if (state_r == S_WRITE) begin
      if (dst_x_r == (out_width - 10'd1)) begin
        dst_x_r <= 10'd0;
        dst_y_r <= dst_y_r + 10'd1;
      end else begin
        dst_x_r <= dst_x_r + 10'd1;
      end
    end
  end

  dsa_bilinear_mac u_mac (
    .p00 (p00_r),
    .p01 (p01_r),
    .p10 (p10_r),
    .p11 (p11_r),
    .fx  (fx_r),
    .fy  (fy_r),
    .pix (mac_pix_s)
  );

endmodule

// File: tb/tb_dsa_bilinear_pixel_engine.sv
// Self-checking bench for dsa_bilinear_pixel_engine with a source RAM and arithmetic reference model.
module tb_dsa_bilinear_pixel_engine;

  logic        clk = 1'b0;
  logic        rst, frame_start, pixel_req;
  logic [9:0]  out_width;
  logic [15:0] scale_step, pixel_index;
  logic        rd_en, wr_en, done_pixel, busy;
  logic [17:0] rd_addr;
  logic [7:0]  rd_data, wr_data;
  logic [15:0] wr_addr;

  int checks = 0;
  int errors = 0;
  int k_pix  = 0;
  int ow_i   = 1;
  int step_i = 256;
  int exp_addr [4];
  logic [7:0]  mem [0:262143];
  logic [17:0] rd_q [$];
  logic [7:0]  got;
  logic [15:0] gaddr;

  dsa_bilinear_pixel_engine dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .out_width(out_width),
    .scale_step(scale_step), .pixel_req(pixel_req), .pixel_index(pixel_index),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .done_pixel(done_pixel), .busy(busy)
  );

  always #5 clk = ~clk;

  // Synchronous source RAM: data one cycle after the strobe
  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

  // Record every issued source read
  always @(negedge clk) begin
    if (rd_en) rd_q.push_back(rd_addr);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] q_at(input int i);
    if (i < rd_q.size()) return 32'(rd_q[i]);
    return 32'hFFFF_FFFF;
  endfunction

  // Reference blend computed directly from the textbook bilinear formula
  function automatic int ref_pix(input int dx, input int dy, input int step);
    int sx, sy, x0, y0, x1, y1, fx, fy, acc, r;
    sx = dx * step;  sy = dy * step;
    x0 = sx / 256;   fx = sx % 256;
    y0 = sy / 256;   fy = sy % 256;
    if (x0 > 511) x0 = 511;
    if (y0 > 511) y0 = 511;
    x1 = (x0 + 1 > 511) ? 511 : x0 + 1;
    y1 = (y0 + 1 > 511) ? 511 : y0 + 1;
    exp_addr[0] = y0 * 512 + x0;
    exp_addr[1] = y0 * 512 + x1;
    exp_addr[2] = y1 * 512 + x0;
    exp_addr[3] = y1 * 512 + x1;
    acc = int'(mem[exp_addr[0]]) * (256 - fx) * (256 - fy)
        + int'(mem[exp_addr[1]]) * fx * (256 - fy)
        + int'(mem[exp_addr[2]]) * (256 - fx) * fy
        + int'(mem[exp_addr[3]]) * fx * fy + 32768;
    r = acc / 65536;
    if (r > 255) r = 255;
    return r;
  endfunction

  task automatic fill_pattern();
    for (int y = 0; y < 512; y++)
      for (int x = 0; x < 512; x++)
        mem[y * 512 + x] = 8'((x + 16 * y) & 255);
  endtask

  task automatic fill_random();
    for (int a = 0; a < 262144; a++) mem[a] = 8'($urandom);
  endtask

  task automatic set_mode(input int step, input int ow);
    @(negedge clk);
    scale_step  = 16'(step);
    out_width   = 10'(ow);
    step_i      = step;
    ow_i        = ow;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    k_pix       = 0;
  endtask

  // One pixel: handshake timing each cycle, then write address/data and read sequence
  task automatic run_pixel(input logic [15:0] idx, output logic [7:0] gdata, output logic [15:0] ga);
    int dx, dy, expd;
    dx   = k_pix % ow_i;
    dy   = (k_pix / ow_i) % 1024;
    expd = ref_pix(dx, dy, step_i);
    rd_q.delete();
    gdata = 8'd0;
    ga    = 16'd0;
    @(negedge clk);
    pixel_req   = 1'b1;
    pixel_index = idx;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 1) begin
        pixel_req   = 1'b0;
        pixel_index = 16'($urandom);
      end
      check("handshake", {busy, done_pixel, wr_en}, {k <= 8, k == 8, k == 8});
      if (k == 8) begin
        check("wr_addr", wr_addr, idx);
        check("wr_data", wr_data, expd);
        gdata = wr_data;
        ga    = wr_addr;
      end
    end
    check("rd_count", rd_q.size(), 4);
    for (int i = 0; i < 4; i++) check("rd_addr", q_at(i), exp_addr[i]);
    k_pix++;
  endtask

  // Launch a pixel and kill it at sample at_k with frame_start or reset
  task automatic abort_pixel(input int at_k, input bit use_rst);
    @(negedge clk);
    pixel_req   = 1'b1;
    pixel_index = 16'hABCD;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) pixel_req = 1'b0;
      check("abort_no_write", {wr_en, done_pixel}, 2'b00);
      check("abort_busy", busy, k <= at_k);
      if (use_rst && (k == at_k + 1)) check("abort_rst_wdata", wr_data, 0);
      if (k == at_k) begin
        if (use_rst) rst = 1'b0;
        else frame_start = 1'b1;
      end
      if (k == at_k + 1) begin
        rst         = 1'b1;
        frame_start = 1'b0;
      end
    end
    k_pix = 0;
  endtask

  initial begin
    rst = 1'b0; frame_start = 1'b0; pixel_req = 1'b0; pixel_index = 16'd0;
    out_width = 10'd1; scale_step = 16'd256;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_strobes", {rd_en, wr_en, done_pixel, busy}, 4'b0000);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    rst = 1'b1;

    // identity scale
    fill_pattern();
    set_mode(256, 4);
    for (int i = 0; i < 4; i++) begin
      run_pixel(16'(i), got, gaddr);
      check("ident_val", got, i);
    end

    // decimation by two, dst(1,0)
    set_mode(512, 256);
    run_pixel(16'd0, got, gaddr);
    run_pixel(16'd1, got, gaddr);
    check("dec_a0", q_at(0), 2);
    check("dec_a1", q_at(1), 3);
    check("dec_a2", q_at(2), 514);
    check("dec_a3", q_at(3), 515);
    check("dec_val", got, 2);

    // fractional blends
    set_mode(384, 2);
    mem[1] = 8'd10; mem[2] = 8'd20; mem[513] = 8'd10; mem[514] = 8'd20;
    run_pixel(16'd0, got, gaddr);
    run_pixel(16'd1, got, gaddr);
    check("frac_15", got, 15);
    mem[513] = 8'd0; mem[514] = 8'd255; mem[1025] = 8'd0; mem[1026] = 8'd0;
    run_pixel(16'd2, got, gaddr);
    run_pixel(16'd3, got, gaddr);
    check("frac_64", got, 64);

    // right-edge clamp and row wrap
    fill_random();
    set_mode(256, 512);
    for (int i = 0; i <= 512; i++) begin
      run_pixel(16'(i), got, gaddr);
      if (i == 511) begin
        check("clamp_x1", q_at(1), 511);
        check("clamp_no512", (q_at(1) == 512 || q_at(3) == 512), 0);
        check("clamp_val", got, mem[511]);
      end
    end

    // latency pixel with index 7
    set_mode(300, 9);
    run_pixel(16'd7, got, gaddr);
    check("idx7", gaddr, 7);

    // abort by frame_start in S_RD2, restart at dst(0,0)
    set_mode(700, 10);
    for (int i = 0; i < 3; i++) run_pixel(16'(100 + i), got, gaddr);
    abort_pixel(4, 1'b0);
    run_pixel(16'd200, got, gaddr);
    run_pixel(16'd201, got, gaddr);

    // abort by reset in S_CALC
    for (int i = 0; i < 2; i++) run_pixel(16'(300 + i), got, gaddr);
    abort_pixel(7, 1'b1);
    run_pixel(16'd400, got, gaddr);

    // random scales and widths, including width 1 and heavy clamping
    for (int r = 0; r < 6; r++) begin
      set_mode((r < 3) ? int'($urandom_range(1, 3000)) : int'($urandom_range(3000, 65535)),
               (r == 0) ? 1 : int'($urandom_range(2, 12)));
      for (int j = 0; j < 12; j++) run_pixel(16'($urandom), got, gaddr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dsa_bilinear_pixel_engine.md
Name: dsa_bilinear_pixel_engine

Overview:
Per-pixel datapath driven by dsa_control_fsm. For each destination pixel it derives source coordinates, fetches four neighbours from a synchronous source-image RAM, computes the Q8 bilinear blend and writes one output byte. It then pulses done_pixel back to the FSM. At top level, pixel_req is tied to the FSM's busy and pixel_index to the FSM's pixel_index.

Parameters:
IMG_WIDTH, 512, source image width in pixels
IMG_HEIGHT, 512, source image height in pixels
ADDR_W, 18, source RAM address width (at least log2(IMG_WIDTH*IMG_HEIGHT))
FRAC_W, 8, fractional bits of scale_step and of the weights

Ports:
clk  in  1  single system clock
rst  in  1  reset; synchronous, active-low (0 = reset), sampled on rising clk
frame_start  in  1  one-cycle pulse; clears destination x/y counters
out_width  in  10  destination width in pixels, valid range 1..512
scale_step  in  16  source/destination ratio, unsigned Q8.8 (256 = 1.0)
pixel_req  in  1  level; FSM requests a pixel (FSM busy)
pixel_index  in  16  destination linear index, used as write address
rd_en  out  1  source RAM read strobe
rd_addr  out  ADDR_W  source RAM address
rd_data  in  8  source RAM data, valid exactly 1 cycle after rd_en
wr_en  out  1  destination RAM write strobe
wr_addr  out  16  destination address, equal to the latched pixel_index
wr_data  out  8  interpolated pixel
done_pixel  out  1  one-cycle pulse; the pixel is written
busy  out  1  high whenever state is not S_IDLE

Behaviour:
- Reset (rst=0 at a clk edge): state goes to S_IDLE. All outputs, dst_x/dst_y, pixel latches and pipeline registers go to 0. Reset mid-operation aborts with no write.
- States: S_IDLE, S_COORD, S_RD0, S_RD1, S_RD2, S_RD3, S_WAIT, S_CALC, S_WRITE.
- S_IDLE:
  - If pixel_req=1 and frame_start=0, latch pixel_index and go to S_COORD.
  - Otherwise stay.
- S_COORD:
  - sx = dst_x*scale_step (26 bit) and sy = dst_y*scale_step.
  - x0 = sx>>8, fx = sx[7:0]; y0 and fy the same way from sy.
  - x0 clamps to IMG_WIDTH-1 and y0 clamps to IMG_HEIGHT-1.
  - x1 = min(x0+1, IMG_WIDTH-1) and y1 = min(y0+1, IMG_HEIGHT-1). When clamping applies, the weights stay as computed.
- S_RD0..S_RD3 assert rd_en=1 with rd_addr = y*IMG_WIDTH+x for p00(x0,y0), p01(x1,y0), p10(x0,y1), p11(x1,y1) in that order. rd_en=0 in every other state.
- Each rd_data is captured one cycle after its read: in S_RD1, S_RD2, S_RD3 and S_WAIT.
- S_CALC:
  - acc = p00*(256-fx)*(256-fy) + p01*fx*(256-fy) + p10*(256-fx)*fy + p11*fx*fy + 32768.
  - acc is 28 bit unsigned. result = acc>>16, saturated to 255, and registered.
- S_WRITE:
  - wr_en=1, wr_addr = latched index, wr_data = result, done_pixel=1 in the same cycle. done_pixel falls to 0 in the next cycle.
  - dst_x increments. When dst_x = out_width-1, dst_x wraps to 0 and dst_y increments; dst_y wraps at 1023.
  - Next state is S_IDLE. The FSM's index update is visible by then, so a back-to-back pixel launches from S_IDLE.
- Latency:
  - pixel_req sampled high in S_IDLE at edge N gives done_pixel=1 during cycle N+8.
  - Throughput is one pixel per 9 cycles.
- frame_start=1 in any state:
  - Clears dst_x/dst_y and forces S_IDLE at the next edge.
  - No write occurs and done_pixel is not pulsed.
  - frame_start has priority over pixel_req and over S_WRITE.
- pixel_req changes while busy are ignored. pixel_index changes after the latch are ignored.
- wr_data, wr_addr and rd_addr hold their last value when their strobes are low.

Decomposition:
- Package dsa_pkg: typedef state_t (enum logic [3:0]), typedef pixel_t (logic [7:0]), constants FRAC_W=8, ONE_Q8=256, ROUND_Q16=32768.
- One sub-module, dsa_bilinear_mac: combinational four-term weighted sum with round and saturate. Inputs are p00..p11, fx and fy; the output is pixel_t. The engine registers its output in S_CALC.

Test Plan:
- Identity: scale_step=256, out_width=4, source(x,y)=x+16y. Four back-to-back pixels give wr_data 0,1,2,3 at wr_addr 0..3 with fx=fy=0.
- Decimation by 2: scale_step=512, out_width=256, pixel at dst(1,0). Expect rd_addr 2, 3, 514, 515 in S_RD0..S_RD3, and wr_data=src(2,0).
- Fractional blend: scale_step=384, dst(1,0) gives x0=1, fx=128. With p00=10, p01=20 and row y=1 equal to row 0, wr_data=15. With p00=0, p01=255, p10=p11=0 and fx=fy=128, wr_data=64.
- Edge clamp: scale_step=256, out_width=512, dst_x=511. Expect x1=511 (no address 512 issued); with fx=0, wr_data=src(511,y).
- Latency and handshake: pixel_req rises at edge N. Expect done_pixel high for exactly cycle N+8 and busy high cycles N+1..N+8. pixel_index=7 gives wr_addr=7.
- Abort: frame_start during S_RD2, or rst=0 during S_CALC. Expect no wr_en and no done_pixel, state S_IDLE, and the next pixel computed with dst_x=dst_y=0.
